im_loader: RTL
==============

Name: im_loader

Overview:
- Writer side of the instruction-memory interface. The core fetches words by byte address; this block fills instruction memory from a host byte stream.
- It receives a framed program: a 16-bit word count, little-endian instruction bytes, then an XOR checksum.
- It writes each assembled 32-bit word into instruction memory and holds the core in reset while a load is in progress.
- It sits beside instruction memory at top level. Its core_hold output is ORed into the core's reset.

Parameters:
- WORDS, 256, capacity of instruction memory in 32-bit words; the maximum legal program length.
- AW, 32, width of the byte address driven to instruction memory.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- LDstart  in  1  single-cycle pulse that begins (or restarts) a load.
- LDbyte  in  8  stream byte.
- LDvalid  in  1  LDbyte is valid.
- LDready  out  1  block accepts a byte this cycle. Handshake = LDvalid & LDready.
- IMwaddr  out  AW  byte address of the word being written (word_index*4).
- IMwdata  out  32  instruction word being written.
- IMwenable  out  1  single-cycle write strobe to instruction memory.
- core_hold  out  1  high while a load is in progress or has failed; holds the core in reset.
- LDdone  out  1  level; the last load completed with a good checksum.
- LDerror  out  1  level; the last load was aborted (oversize length or bad checksum).

Behaviour:
- Reset (async, any cycle) clears all registers:
  - state = IDLE.
  - LDready=0, IMwenable=0, IMwaddr=0, IMwdata=0.
  - core_hold=0, LDdone=0, LDerror=0.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- LDstart in any state, without reset:
  - Go to LEN_LO next cycle.
  - Clear the word counter, byte lane and checksum.
  - core_hold=1, LDdone=0, LDerror=0.
  - A handshake in the LDstart cycle is ignored.
- LDready is 1 only in LEN_LO, LEN_HI, DATA and CHECK. It is 0 elsewhere and never depends combinationally on LDvalid.
- Byte framing:
  - LEN_LO takes len[7:0]; LEN_HI takes len[15:8]. Both bytes are XORed into the checksum.
  - After LEN_HI, the next state is decided by the length:
    - len > WORDS: go to ERROR.
    - len == 0: go to CHECK.
    - otherwise: go to DATA.
- DATA:
  - Each accepted byte fills lane 0..3 of the assembly register, LSB first, and is XORed into the checksum.
  - On the lane-3 handshake, copy the assembled word to IMwdata and set IMwaddr = word_index<<2.
  - IMwenable pulses for exactly the following cycle (one-cycle latency), then word_index increments.
  - LDready stays 1 during the write cycle. Back-to-back bytes are accepted with no bubble.
  - After the lane-3 byte of word len-1, go to CHECK.
- CHECK:
  - Accept one byte.
  - If it equals the running XOR of all previous frame bytes: go to DONE, LDdone=1, core_hold=0.
  - Otherwise: go to ERROR, LDerror=1, core_hold stays 1.
- DONE and ERROR are held until LDstart or reset. Words already written are not rolled back on error.
- LDvalid low in any accepting state: the state machine waits indefinitely. There is no timeout.
- The counter never exceeds WORDS-1. The address width covers WORDS*4-1; no wrap is possible because oversize lengths are rejected.
- A reset during DATA discards the partial word. No IMwenable is issued after reset.

Decomposition:
- Shared package im_loader_pkg holds:
  - the state encoding enum;
  - the frame-constant LEN_BYTES=2;
  - the byte-lane count 4.
- One natural sub-module, ld_word_pack:
  - byte-lane counter plus little-endian 32-bit assembly register;
  - outputs word_ready and word.
  - The FSM, counter, checksum and handshake remain in im_loader.

Test Plan:
- Good 1-word load. Stream 01 00 13 05 A0 00 B7, LDvalid held high.
  - IMwenable pulses once with IMwaddr=0x0, IMwdata=0x00A00513.
  - LDdone=1, core_hold=0, LDready=0.
- Zero-length load. Stream 00 00 00.
  - No IMwenable.
  - DONE after the third byte.
- Oversize length (WORDS=256). Stream 01 01.
  - ERROR on the cycle after the second byte, LDerror=1, core_hold=1, no writes.
  - Further bytes are not accepted.
- Bad checksum. Stream 01 00 13 05 A0 00 B6.
  - The word is still written.
  - ERROR, LDerror=1, core_hold stays 1.
- Backpressure and multiple words. Stream a 3-word frame with LDvalid toggling randomly.
  - Writes to addresses 0x0, 0x4 and 0x8 with the correct words.
  - Exactly 3 strobes, DONE.
- Abort paths. Start a 2-word load:
  - Assert reset after 3 data bytes: all outputs return to reset values and no write occurs.
  - Repeat, but pulse LDstart instead of reset: the load restarts at LEN_LO, and the following good frame writes from address 0x0.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the loader state encoding and the framing constants used by
// im_loader and its byte-packing sub-module.
package im_loader_pkg;

    // Loader states, in frame order; DONE and ERROR are terminal until restart.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } ld_state_t;

    // Number of length bytes at the head of a frame.
    localparam int LEN_BYTES = 2;

    // Bytes per 32-bit instruction word.
    localparam int LANES = 4;

endpackage

// File: rtl/ld_word_pack.sv
// Little-endian byte-to-word assembler.
// Ports:
//   clk, reset   - clock and asynchronous active-high reset
//   clear        - synchronous restart of the lane counter (new load)
//   byte_en      - a data byte is accepted this cycle
//   byte_in      - the accepted byte
//   word_ready   - this cycle's byte completes a word (lane 3)
//   word         - the completed word, valid while word_ready is high
module ld_word_pack
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_ready,
    output logic [31:0] word
);

    localparam int LW = $clog2(LANES);

    logic [LW-1:0] lane;
    logic [23:0]   low_bytes;

    // Lanes 0..2 are stored; the lane-3 byte is forwarded straight into the
    // word so the completed word is available in the same cycle it arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane      <= '0;
            low_bytes <= '0;
        end else if (clear) begin
            lane      <= '0;
        end else if (byte_en) begin
            case (lane)
                LW'(0):  low_bytes[7:0]   <= byte_in;
                LW'(1):  low_bytes[15:8]  <= byte_in;
                LW'(2):  low_bytes[23:16] <= byte_in;
                default: ;
            endcase
            lane <= lane + LW'(1);
        end
    end

    assign word_ready = byte_en && (lane == LW'(LANES - 1));
    assign word       = {byte_in, low_bytes};

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: receives a framed program from a host byte
// stream (16-bit little-endian word count, instruction bytes LSB first,
// XOR checksum), writes each word into instruction memory and holds the
// core in reset while a load is in progress or has failed.
// Ports:
//   clk, reset          - clock and asynchronous active-high reset
//   LDstart             - one-cycle pulse that begins or restarts a load
//   LDbyte, LDvalid     - host byte stream
//   LDready             - loader accepts a byte this cycle
//   IMwaddr/IMwdata     - byte address and data of the word being written
//   IMwenable           - one-cycle write strobe
//   core_hold           - keeps the core in reset
//   LDdone, LDerror     - outcome of the last load
module im_loader
    import im_loader_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          LDstart,
    input  logic [7:0]    LDbyte,
    input  logic          LDvalid,
    output logic          LDready,
    output logic [AW-1:0] IMwaddr,
    output logic [31:0]   IMwdata,
    output logic          IMwenable,
    output logic          core_hold,
    output logic          LDdone,
    output logic          LDerror
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    ld_state_t   state, next_state;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [IW-1:0] word_idx;
    logic [7:0]  csum;
    logic        hs;
    logic        oversize;
    logic        last_word;
    logic        csum_ok;
    logic        word_ready;
    logic [31:0] word;

    assign LDready = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                     (state == ST_DATA)   || (state == ST_CHECK);

    // A start pulse wins over any byte offered in the same cycle.
    assign hs        = LDvalid && LDready && !LDstart;
    assign len_full  = {LDbyte, len[7:0]};
    assign oversize  = 32'(len_full) > 32'(WORDS);
    assign last_word = (16'(word_idx) == (len - 16'd1));
    assign csum_ok   = (LDbyte == csum);

    ld_word_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .clear      (LDstart),
        .byte_en    (hs && (state == ST_DATA)),
        .byte_in    (LDbyte),
        .word_ready (word_ready),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Frame sequencing; a zero-length frame skips straight to the checksum.
    always_comb begin
        next_state = state;
        if (LDstart) begin
            next_state = ST_LEN_LO;
        end else begin
            case (state)
                ST_LEN_LO: if (hs) next_state = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (hs) begin
                        if (oversize)              next_state = ST_ERROR;
                        else if (len_full == 16'd0) next_state = ST_CHECK;
                        else                        next_state = ST_DATA;
                    end
                end
                ST_DATA:   if (word_ready && last_word) next_state = ST_CHECK;
                ST_CHECK:  if (hs) next_state = csum_ok ? ST_DONE : ST_ERROR;
                default:   next_state = state;
            endcase
        end
    end

    // Datapath: length capture, running checksum, word index, memory write
    // port and status flags. The word index only advances on non-final
    // words so it never reaches WORDS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len       <= '0;
            word_idx  <= '0;
            csum      <= '0;
            IMwaddr   <= '0;
            IMwdata   <= '0;
            IMwenable <= 1'b0;
            core_hold <= 1'b0;
            LDdone    <= 1'b0;
            LDerror   <= 1'b0;
        end else begin
            IMwenable <= 1'b0;
            if (LDstart) begin
                len       <= '0;
                word_idx  <= '0;
                csum      <= '0;
                core_hold <= 1'b1;
                LDdone    <= 1'b0;
                LDerror   <= 1'b0;
            end else if (hs) begin
                case (state)
                    ST_LEN_LO: begin
                        len[7:0] <= LDbyte;
                        csum     <= csum ^ LDbyte;
                    end
                    ST_LEN_HI: begin
                        len[15:8] <= LDbyte;
                        csum      <= csum ^ LDbyte;
                        if (oversize) LDerror <= 1'b1;
                    end
                    ST_DATA: begin
                        csum <= csum ^ LDbyte;
                        if (word_ready) begin
                            IMwdata   <= word;
                            IMwaddr   <= AW'({word_idx, 2'b00});
                            IMwenable <= 1'b1;
                            if (!last_word) word_idx <= word_idx + IW'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (csum_ok) begin
                            LDdone    <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            LDerror   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
